// File: rtl/sisc_proc_if.sv
// ============================================================================
// sisc_proc_if : instruction / status / writeback bundle for sisc_proc
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface sisc_proc_if;
  logic [31:0] ir;
  logic [3:0]  stat;
  logic        halted;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;

  modport master (
    output ir,
    input  stat, halted, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  ir,
    output stat, halted, wb_en, wb_addr, wb_data
  );
endinterface

`default_nettype wire

// File: rtl/sisc_proc.sv
// ============================================================================
// sisc_proc : multi-cycle (5 cycles/instruction) 32-bit ALU processor core
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sisc_proc (
  input  logic        clk,
  input  logic        rst_f,
  sisc_proc_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_START0    = 3'd0,
    ST_START1    = 3'd1,
    ST_FETCH     = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_MEM       = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_HALT      = 3'd7
  } state_e;

  state_e      state_q;
  logic [31:0] rf_q [16];
  logic [31:0] alu_q;
  logic [3:0]  stat_q;
  logic        wb_en_q;
  logic [3:0]  wb_addr_q;
  logic        halted_q;

  logic [3:0]  opcode, func, rd, rs, rt;
  logic [15:0] imm;
  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;
  logic [32:0] add_full, sub_full;
  logic        is_alu, func_ok, does_write;
  logic [31:0] alu_d;
  logic [3:0]  stat_d;
  logic        c_flag, v_flag;

  assign opcode = bus.ir[31:28];
  assign func   = bus.ir[27:24];
  assign rd     = bus.ir[23:20];
  assign rs     = bus.ir[19:16];
  assign rt     = bus.ir[15:12];
  assign imm    = bus.ir[15:0];

  assign op_a  = (rs == 4'd0) ? 32'd0 : rf_q[rs];
  assign op_b  = (opcode == 4'h2) ? {16'd0, imm} : ((rt == 4'd0) ? 32'd0 : rf_q[rt]);
  assign shamt = op_b[4:0];

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} - {1'b0, op_b};

  assign is_alu     = (opcode == 4'h1) || (opcode == 4'h2);
  assign func_ok    = (func >= 4'h1) && (func <= 4'hB);
  assign does_write = func_ok && (func != 4'h3);

  always_comb begin
    alu_d  = 32'd0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (func)
      4'h1: begin
        alu_d  = add_full[31:0];
        c_flag = add_full[32];
        v_flag = (op_a[31] == op_b[31]) && (add_full[31] != op_a[31]);
      end
      4'h2, 4'h3: begin
        // The 33rd bit of the widened difference is the unsigned borrow.
        alu_d  = sub_full[31:0];
        c_flag = sub_full[32];
        v_flag = (op_a[31] != op_b[31]) && (sub_full[31] != op_a[31]);
      end
      4'h4: alu_d = ~op_a;
      4'h5: alu_d = op_a | op_b;
      4'h6: alu_d = op_a & op_b;
      4'h7: alu_d = op_a ^ op_b;
      4'h8: alu_d = (shamt == 5'd0) ? op_a
                    : ((op_a >> shamt) | (op_a << (6'd32 - {1'b0, shamt})));
      4'h9: alu_d = (shamt == 5'd0) ? op_a
                    : ((op_a << shamt) | (op_a >> (6'd32 - {1'b0, shamt})));
      4'hA: alu_d = op_a >> shamt;
      4'hB: alu_d = op_a << shamt;
      default: alu_d = 32'd0;
    endcase
    stat_d = {c_flag, v_flag, alu_d[31], (alu_d == 32'd0)};
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q   <= ST_START0;
      alu_q     <= 32'd0;
      stat_q    <= 4'd0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= 4'd0;
      halted_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      case (state_q)
        ST_START0:  state_q <= ST_START1;
        ST_START1:  state_q <= ST_FETCH;
        ST_FETCH:   state_q <= ST_DECODE;
        ST_DECODE: begin
          if (opcode == 4'hF) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (is_alu && func_ok) begin
            alu_q  <= alu_d;
            stat_q <= stat_d;
          end
          state_q <= ST_MEM;
        end
        ST_MEM: begin
          wb_en_q   <= is_alu && does_write;
          wb_addr_q <= rd;
          state_q   <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          // R0 is hardwired to zero, so its write is silently dropped.
          if (wb_en_q && (wb_addr_q != 4'd0)) begin
            rf_q[wb_addr_q] <= alu_q;
          end
          wb_en_q <= 1'b0;
          state_q <= ST_FETCH;
        end
        ST_HALT:    state_q <= ST_HALT;
        default:    state_q <= ST_START0;
      endcase
    end
  end

  assign bus.stat    = stat_q;
  assign bus.halted  = halted_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = alu_q;

endmodule

`default_nettype wire

// File: tb/tb_sisc_proc.sv
// ============================================================================
// tb_sisc_proc : table-driven, hand-sequenced and randomized checks of sisc_proc
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_sisc_proc;

  logic clk;
  logic rst_f;
  sisc_proc_if bus ();

  sisc_proc dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // Reference state: architectural registers and status flags.
  logic [31:0] m_rf [16];
  logic [3:0]  m_stat;

  logic        s_wen;
  logic [3:0]  s_addr;
  logic [31:0] s_data;
  logic [3:0]  s_stat;

  typedef struct {
    logic [31:0] ir;
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        cs;
    logic [3:0]  stat;
  } vec_t;

  vec_t t1[$];
  vec_t t2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else npass++;
  endtask

  function automatic logic [31:0] mk_r(logic [3:0] fn, logic [3:0] rd, logic [3:0] rs, logic [3:0] rt);
    return {4'h1, fn, rd, rs, rt, 12'h000};
  endfunction

  function automatic logic [31:0] mk_i(logic [3:0] fn, logic [3:0] rd, logic [3:0] rs, logic [15:0] imm);
    return {4'h2, fn, rd, rs, imm};
  endfunction

  function automatic vec_t mkv(logic [31:0] ir, logic wen, logic [3:0] addr, logic [31:0] data,
                               logic cs, logic [3:0] stat);
    vec_t v;
    v.ir = ir; v.wen = wen; v.addr = addr; v.data = data; v.cs = cs; v.stat = stat;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    m_stat = 4'd0;
  endtask

  task automatic model_exec(input logic [31:0] ir, output logic wen, output logic [3:0] addr,
                            output logic [31:0] data);
    logic [3:0]  op, fn;
    logic [31:0] a, b, r;
    logic [63:0] dbl, wide;
    longint      sa, sb, s;
    int          sh;
    logic        c, v;
    op = ir[31:28];
    fn = ir[27:24];
    a  = m_rf[ir[19:16]];
    b  = (op == 4'h2) ? {16'd0, ir[15:0]} : m_rf[ir[15:12]];
    sh = int'(b[4:0]);
    sa = $signed(a);
    sb = $signed(b);
    wen = 1'b0; addr = ir[23:20]; data = 32'd0;
    c = 1'b0; v = 1'b0; r = 32'd0;
    if ((op == 4'h1 || op == 4'h2) && fn >= 4'h1 && fn <= 4'hB) begin
      dbl = {a, a};
      case (fn)
        4'h1: begin
          r = a + b;
          wide = {32'd0, a} + {32'd0, b};
          c = wide > 64'h0000_0000_FFFF_FFFF;
          s = sa + sb;
          v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'h2, 4'h3: begin
          r = a - b;
          c = a < b;
          s = sa - sb;
          v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'h4: r = ~a;
        4'h5: r = a | b;
        4'h6: r = a & b;
        4'h7: r = a ^ b;
        4'h8: begin wide = dbl >> sh; r = wide[31:0];  end
        4'h9: begin wide = dbl << sh; r = wide[63:32]; end
        4'hA: r = a >> sh;
        default: r = a << sh;
      endcase
      m_stat = {c, v, r[31], (r == 32'd0)};
      wen  = (fn != 4'h3);
      data = r;
      if (wen && addr != 4'd0) m_rf[addr] = r;
    end
  endtask

  // Entered and left at the falling edge of a FETCH cycle.
  task automatic run_instr(input logic [31:0] ir);
    logic        ok, m_wen;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    ok = (bus.wb_en == 1'b0) && (bus.halted == 1'b0);
    bus.ir = ir;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 3 && bus.wb_en !== 1'b0) ok = 1'b0;
    end
    s_wen  = bus.wb_en;
    s_addr = bus.wb_addr;
    s_data = bus.wb_data;
    s_stat = bus.stat;
    model_exec(ir, m_wen, m_addr, m_data);
    chk("wb_en_idle", {31'd0, ok}, 32'd1);
    chk("model_wen", {31'd0, s_wen}, {31'd0, m_wen});
    if (m_wen) begin
      chk("model_addr", {28'd0, s_addr}, {28'd0, m_addr});
      chk("model_data", s_data, m_data);
    end
    chk("model_stat", {28'd0, s_stat}, {28'd0, m_stat});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_seq();
    @(negedge clk);
    rst_f = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_f = 1'b0;
    model_reset();
    chk("rst_halted",  {31'd0, bus.halted}, 32'd0);
    chk("rst_wb_en",   {31'd0, bus.wb_en},  32'd0);
    chk("rst_stat",    {28'd0, bus.stat},   32'd0);
    chk("rst_wb_data", bus.wb_data,         32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_table(input vec_t v);
    run_instr(v.ir);
    chk("tbl_wen", {31'd0, s_wen}, {31'd0, v.wen});
    if (v.wen) begin
      chk("tbl_addr", {28'd0, s_addr}, {28'd0, v.addr});
      chk("tbl_data", s_data, v.data);
    end
    if (v.cs) chk("tbl_stat", {28'd0, s_stat}, {28'd0, v.stat});
  endtask

  initial begin
    logic [31:0] rnd, ir;
    logic [3:0]  op;
    logic        ok, mw;
    logic [3:0]  ma;
    logic [31:0] md;
    int          n;

    rst_f  = 1'b0;
    bus.ir = 32'd0;
    model_reset();

    // Long dependent sequence, then read back every register via Rk = Rk + R0.
    t1.push_back(mkv(mk_i(4'h1, 4'd1, 4'd0, 16'd1), 1, 4'd1, 32'h0000_0001, 1, 4'b0000));
    t1.push_back(mkv(mk_r(4'h1, 4'd2, 4'd1, 4'd1),  1, 4'd2, 32'h0000_0002, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'hB, 4'd3, 4'd2, 4'd2),  1, 4'd3, 32'h0000_0008, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h2, 4'd4, 4'd1, 4'd2),  1, 4'd4, 32'hFFFF_FFFF, 1, 4'b1010));
    t1.push_back(mkv(mk_r(4'hA, 4'd4, 4'd4, 4'd3),  1, 4'd4, 32'h00FF_FFFF, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h7, 4'd2, 4'd3, 4'd4),  1, 4'd2, 32'h00FF_FFF7, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h4, 4'd2, 4'd2, 4'd0),  1, 4'd2, 32'hFF00_0008, 1, 4'b0010));
    t1.push_back(mkv(mk_r(4'h9, 4'd4, 4'd2, 4'd1),  1, 4'd4, 32'hFE00_0011, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h5, 4'd5, 4'd2, 4'd4),  1, 4'd5, 32'hFF00_0019, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h6, 4'd3, 4'd2, 4'd4),  1, 4'd3, 32'hFE00_0000, 1, 4'b0010));
    t1.push_back(mkv(mk_r(4'h1, 4'd1, 4'd1, 4'd0),  1, 4'd1, 32'h0000_0001, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h1, 4'd2, 4'd2, 4'd0),  1, 4'd2, 32'hFF00_0008, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h1, 4'd3, 4'd3, 4'd0),  1, 4'd3, 32'hFE00_0000, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h1, 4'd4, 4'd4, 4'd0),  1, 4'd4, 32'hFE00_0011, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h1, 4'd5, 4'd5, 4'd0),  1, 4'd5, 32'hFF00_0019, 0, 4'b0000));
    t1.push_back(mkv(mk_r(4'h1, 4'd6, 4'd6, 4'd0),  1, 4'd6, 32'h0000_0000, 1, 4'b0001));

    // Flag corner cases, R0 write, NOP, CMP and undefined operations.
    t2.push_back(mkv(mk_i(4'h1, 4'd1, 4'd0, 16'd1), 1, 4'd1, 32'h0000_0001, 1, 4'b0000));
    t2.push_back(mkv(mk_r(4'h2, 4'd2, 4'd1, 4'd1),  1, 4'd2, 32'h0000_0000, 1, 4'b0001));
    t2.push_back(mkv(mk_r(4'h2, 4'd2, 4'd0, 4'd1),  1, 4'd2, 32'hFFFF_FFFF, 1, 4'b1010));
    t2.push_back(mkv(mk_r(4'h8, 4'd3, 4'd1, 4'd1),  1, 4'd3, 32'h8000_0000, 1, 4'b0010));
    t2.push_back(mkv(mk_r(4'h1, 4'd4, 4'd2, 4'd3),  1, 4'd4, 32'h7FFF_FFFF, 1, 4'b1100));
    t2.push_back(mkv(mk_i(4'h1, 4'd0, 4'd0, 16'd5), 1, 4'd0, 32'h0000_0005, 1, 4'b0000));
    t2.push_back(mkv(mk_r(4'h1, 4'd6, 4'd0, 4'd0),  1, 4'd6, 32'h0000_0000, 1, 4'b0001));
    t2.push_back(mkv(32'h0000_0000,                 0, 4'd0, 32'h0000_0000, 1, 4'b0001));
    t2.push_back(mkv(mk_r(4'h3, 4'd7, 4'd1, 4'd2),  0, 4'd0, 32'h0000_0000, 1, 4'b1000));
    t2.push_back(mkv(mk_r(4'hC, 4'd8, 4'd1, 4'd1),  0, 4'd0, 32'h0000_0000, 1, 4'b1000));
    t2.push_back(mkv(32'h5123_4000,                 0, 4'd0, 32'h0000_0000, 1, 4'b1000));

    reset_seq();
    foreach (t1[i]) run_table(t1[i]);

    reset_seq();
    foreach (t2[i]) run_table(t2[i]);

    for (int i = 0; i < 40; i++) begin
      rnd = $urandom();
      n = int'($urandom_range(0, 9));
      op = (n == 0) ? 4'h0 : (n <= 4) ? 4'h1 : (n <= 8) ? 4'h2 : 4'h6;
      ir = {op, rnd[27:0]};
      run_instr(ir);
    end

    // HALT: stays halted, no writebacks, even with an ALU op on ir.
    bus.ir = 32'hF000_0000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("halt_entered", {31'd0, bus.halted}, 32'd1);
    bus.ir = mk_i(4'h1, 4'd1, 4'd1, 16'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wb_en !== 1'b0 || bus.halted !== 1'b1) ok = 1'b0;
    end
    chk("halt_sticky", {31'd0, ok}, 32'd1);

    reset_seq();
    for (int k = 1; k < 16; k++) begin
      run_instr(mk_r(4'h1, k[3:0], k[3:0], 4'd0));
      chk("rf_cleared", s_data, 32'd0);
    end

    // First writeback lands on the 6th rising edge after reset release.
    @(negedge clk);
    rst_f  = 1'b1;
    bus.ir = mk_i(4'h1, 4'd9, 4'd0, 16'd3);
    @(posedge clk);
    @(negedge clk);
    rst_f = 1'b0;
    model_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.wb_en === 1'b1) break;
    end
    chk("first_wb_edge", n, 32'd6);
    chk("first_wb_data", bus.wb_data, 32'd3);
    model_exec(bus.ir, mw, ma, md);
    @(posedge clk);
    @(negedge clk);

    // Reset during EXECUTE of a flag-setting SUB aborts it.
    bus.ir = mk_r(4'h2, 4'd2, 4'd0, 4'd9);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    reset_seq();
    run_instr(mk_r(4'h1, 4'd9, 4'd9, 4'd0));
    chk("abort_r9", s_data, 32'd0);
    run_instr(mk_r(4'h1, 4'd2, 4'd2, 4'd0));
    chk("abort_r2", s_data, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
